// File: rtl/sc_ar_entry_packer_pkg.sv
// Shared definitions for the SC AR entry stage: AXI AR field widths, payload
// field offsets (relative to the end of araddr) and credit-counter sizing.
package sc_ar_pkg;

  localparam int unsigned LEN_W   = 8;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned LOCK_W  = 1;
  localparam int unsigned CACHE_W = 4;
  localparam int unsigned PROT_W  = 3;
  localparam int unsigned QOS_W   = 4;

  // Offsets above araddr; araddr itself sits at bit 0.
  localparam int unsigned OFF_LEN   = 0;
  localparam int unsigned OFF_SIZE  = OFF_LEN   + LEN_W;
  localparam int unsigned OFF_BURST = OFF_SIZE  + SIZE_W;
  localparam int unsigned OFF_LOCK  = OFF_BURST + BURST_W;
  localparam int unsigned OFF_CACHE = OFF_LOCK  + LOCK_W;
  localparam int unsigned OFF_PROT  = OFF_CACHE + CACHE_W;
  localparam int unsigned OFF_QOS   = OFF_PROT  + PROT_W;
  localparam int unsigned OFF_ID    = OFF_QOS   + QOS_W;
  localparam int unsigned CTRL_W    = OFF_ID;

  function automatic int unsigned credit_cnt_w(input int unsigned max_credits);
    int unsigned w;
    w = $clog2(max_credits + 1);
    return (w > 4) ? w : 4;
  endfunction

endpackage

// File: rtl/sc_ar_entry_packer_skid_fifo2.sv
// Two-entry FIFO with a registered not-full flag (ready), low during reset.
module sc_skid_fifo2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         ready
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic [1:0]   count_nxt;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count_nxt;
      ready <= (count_nxt != 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == 2'd0);

endmodule

// File: rtl/sc_ar_entry_packer.sv
// AXI AR entry stage: packs AR beats, buffers two, issues on SC credits.
// Optional perf counters enabled by defining SC_AR_PERF_CNT_EN.
module sc_ar_entry_packer
  import sc_ar_pkg::*;
#(
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned USER_W    = 83,
  parameter int unsigned CREDITS   = 4,
  parameter int unsigned ROUTE_BIT = 31,
  localparam int unsigned PAYLD_W  = USER_W + ID_W + ADDR_W + CTRL_W
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [LEN_W-1:0]    s_axi_arlen,
  input  logic [SIZE_W-1:0]   s_axi_arsize,
  input  logic [BURST_W-1:0]  s_axi_arburst,
  input  logic                s_axi_arlock,
  input  logic [CACHE_W-1:0]  s_axi_arcache,
  input  logic [PROT_W-1:0]   s_axi_arprot,
  input  logic [QOS_W-1:0]    s_axi_arqos,
  input  logic [USER_W-1:0]   s_axi_aruser,
  output logic                m_sc_req,
  output logic                m_sc_send,
  output logic                m_sc_info,
  output logic [PAYLD_W-1:0]  m_sc_payld,
  input  logic                m_sc_recv,
  output logic                err_credit_ovf
`ifdef SC_AR_PERF_CNT_EN
  ,
  output logic [31:0]         perf_issue_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  localparam int unsigned CW = credit_cnt_w(CREDITS);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

  logic [PAYLD_W-1:0] ar_payld;
  logic [PAYLD_W-1:0] fifo_dout;
  logic [PAYLD_W-1:0] issue_payld;
  logic               fifo_empty;
  logic               hs;
  logic               credit_ok;
  logic               issue;
  logic               push;
  logic               pop;
  logic [CW-1:0]      credit;
  logic [CW-1:0]      credit_nxt;
  logic               ovf;

  always_comb begin
    ar_payld = '0;
    ar_payld[ADDR_W-1:0]                   = s_axi_araddr;
    ar_payld[ADDR_W+OFF_LEN   +: LEN_W]    = s_axi_arlen;
    ar_payld[ADDR_W+OFF_SIZE  +: SIZE_W]   = s_axi_arsize;
    ar_payld[ADDR_W+OFF_BURST +: BURST_W]  = s_axi_arburst;
    ar_payld[ADDR_W+OFF_LOCK]              = s_axi_arlock;
    ar_payld[ADDR_W+OFF_CACHE +: CACHE_W]  = s_axi_arcache;
    ar_payld[ADDR_W+OFF_PROT  +: PROT_W]   = s_axi_arprot;
    ar_payld[ADDR_W+OFF_QOS   +: QOS_W]    = s_axi_arqos;
    ar_payld[ADDR_W+OFF_ID    +: ID_W]     = s_axi_arid;
    ar_payld[ADDR_W+OFF_ID+ID_W +: USER_W] = s_axi_aruser;
  end

  // A same-cycle credit return may fund this edge's issue; an empty FIFO
  // lets the incoming beat bypass straight to the output register.
  assign hs          = s_axi_arvalid && s_axi_arready;
  assign credit_ok   = (credit != '0) || m_sc_recv;
  assign issue       = credit_ok && (!fifo_empty || hs);
  assign pop         = issue && !fifo_empty;
  assign push        = hs && !(issue && fifo_empty);
  assign issue_payld = fifo_empty ? ar_payld : fifo_dout;
  assign m_sc_req    = !fifo_empty || s_axi_arvalid;

  sc_skid_fifo2 #(
    .W (PAYLD_W)
  ) u_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (push),
    .din   (ar_payld),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .ready (s_axi_arready)
  );

  always_comb begin
    credit_nxt = credit;
    ovf        = 1'b0;
    case ({m_sc_recv, issue})
      2'b10: begin
        if (credit == CREDIT_MAX) ovf = 1'b1;
        else credit_nxt = credit + CW'(1);
      end
      2'b01:   credit_nxt = credit - CW'(1);
      default: credit_nxt = credit;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      credit         <= CREDIT_MAX;
      err_credit_ovf <= 1'b0;
      m_sc_send      <= 1'b0;
      m_sc_info      <= 1'b0;
      m_sc_payld     <= '0;
    end else begin
      credit    <= credit_nxt;
      m_sc_send <= issue;
      if (ovf) err_credit_ovf <= 1'b1;
      if (issue) begin
        m_sc_payld <= issue_payld;
        m_sc_info  <= issue_payld[ROUTE_BIT];
      end
    end
  end

`ifdef SC_AR_PERF_CNT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (m_sc_send) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (!fifo_empty && credit == '0) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sc_ar_entry_packer.sv
// Scoreboard bench for sc_ar_entry_packer: queue-based reference model of
// pending requests and credits, monitor compares on the falling edge.
module tb_sc_ar_entry_packer;
  import sc_ar_pkg::*;

  localparam int unsigned ADDR_W    = 64;
  localparam int unsigned ID_W      = 2;
  localparam int unsigned USER_W    = 83;
  localparam int unsigned CREDITS   = 4;
  localparam int unsigned ROUTE_BIT = 31;
  localparam int unsigned PW        = USER_W + ID_W + ADDR_W + 25;

  logic               aclk = 1'b0;
  logic               aresetn = 1'b0;
  logic               s_axi_arvalid = 1'b0;
  logic               s_axi_arready;
  logic [ADDR_W-1:0]  s_axi_araddr = '0;
  logic [ID_W-1:0]    s_axi_arid = '0;
  logic [7:0]         s_axi_arlen = '0;
  logic [2:0]         s_axi_arsize = '0;
  logic [1:0]         s_axi_arburst = '0;
  logic               s_axi_arlock = 1'b0;
  logic [3:0]         s_axi_arcache = '0;
  logic [2:0]         s_axi_arprot = '0;
  logic [3:0]         s_axi_arqos = '0;
  logic [USER_W-1:0]  s_axi_aruser = '0;
  logic               m_sc_req;
  logic               m_sc_send;
  logic               m_sc_info;
  logic [PW-1:0]      m_sc_payld;
  logic               m_sc_recv = 1'b0;
  logic               err_credit_ovf;

  int errors = 0;
  int checks = 0;

  logic [PW-1:0] pend[$];
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] mon_exp;
  int            cred_m = CREDITS;
  bit            arready_m = 1'b0;
  bit            err_m = 1'b0;
  bit            last_hs = 1'b0;
  bit            m_hs, m_avail, m_issue;
  logic [95:0]   tmp96;

  sc_ar_entry_packer #(
    .ADDR_W    (ADDR_W),
    .ID_W      (ID_W),
    .USER_W    (USER_W),
    .CREDITS   (CREDITS),
    .ROUTE_BIT (ROUTE_BIT)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_axi_arvalid  (s_axi_arvalid),
    .s_axi_arready  (s_axi_arready),
    .s_axi_araddr   (s_axi_araddr),
    .s_axi_arid     (s_axi_arid),
    .s_axi_arlen    (s_axi_arlen),
    .s_axi_arsize   (s_axi_arsize),
    .s_axi_arburst  (s_axi_arburst),
    .s_axi_arlock   (s_axi_arlock),
    .s_axi_arcache  (s_axi_arcache),
    .s_axi_arprot   (s_axi_arprot),
    .s_axi_arqos    (s_axi_arqos),
    .s_axi_aruser   (s_axi_aruser),
    .m_sc_req       (m_sc_req),
    .m_sc_send      (m_sc_send),
    .m_sc_info      (m_sc_info),
    .m_sc_payld     (m_sc_payld),
    .m_sc_recv      (m_sc_recv),
    .err_credit_ovf (err_credit_ovf)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] pack_ar();
    return {s_axi_aruser, s_axi_arid, s_axi_arqos, s_axi_arprot, s_axi_arcache,
            s_axi_arlock, s_axi_arburst, s_axi_arsize, s_axi_arlen, s_axi_araddr};
  endfunction

  task automatic rand_fields();
    s_axi_araddr  = {$urandom, $urandom};
    s_axi_arid    = ID_W'($urandom);
    s_axi_arlen   = 8'($urandom);
    s_axi_arsize  = 3'($urandom);
    s_axi_arburst = 2'($urandom);
    s_axi_arlock  = 1'($urandom);
    s_axi_arcache = 4'($urandom);
    s_axi_arprot  = 3'($urandom);
    s_axi_arqos   = 4'($urandom);
    tmp96         = {$urandom, $urandom, $urandom};
    s_axi_aruser  = tmp96[USER_W-1:0];
  endtask

  task automatic model_reset();
    pend.delete();
    exp_q.delete();
    cred_m    = CREDITS;
    arready_m = 1'b0;
    err_m     = 1'b0;
    last_hs   = 1'b0;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_arready"}, PW'(s_axi_arready), '0);
    chk({tag, "_req"},     PW'(m_sc_req), '0);
    chk({tag, "_send"},    PW'(m_sc_send), '0);
    chk({tag, "_info"},    PW'(m_sc_info), '0);
    chk({tag, "_payld"},   m_sc_payld, '0);
    chk({tag, "_err"},     PW'(err_credit_ovf), '0);
  endtask

  // Reference model: a request list plus a credit count, stepped per edge.
  always @(posedge aclk) begin
    if (aresetn) begin
      m_hs    = s_axi_arvalid && arready_m;
      last_hs = m_hs;
      if (m_hs) pend.push_back(pack_ar());
      m_avail = (cred_m > 0) || m_sc_recv;
      m_issue = m_avail && (pend.size() != 0);
      if (m_issue) exp_q.push_back(pend.pop_front());
      if (m_sc_recv && !m_issue) begin
        if (cred_m == CREDITS) err_m = 1'b1;
        else cred_m++;
      end else if (m_issue && !m_sc_recv) begin
        cred_m--;
      end
      arready_m = (pend.size() < 2);
    end
  end

  always @(negedge aclk) begin
    if (aresetn) begin
      chk("send", PW'(m_sc_send), PW'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        if (m_sc_send) begin
          chk("payld", m_sc_payld, mon_exp);
          chk("info", PW'(m_sc_info), PW'(mon_exp[ROUTE_BIT]));
        end
      end
      chk("arready", PW'(s_axi_arready), PW'(arready_m));
      chk("req", PW'(m_sc_req), PW'((pend.size() != 0) || s_axi_arvalid));
      chk("err_ovf", PW'(err_credit_ovf), PW'(err_m));
    end
  end

  task automatic drive(input bit v, input bit r);
    @(negedge aclk);
    #2;
    if (v && (!s_axi_arvalid || last_hs)) rand_fields();
    s_axi_arvalid = v;
    m_sc_recv     = r;
  endtask

  task automatic drive_fixed_ar();
    @(negedge aclk);
    #2;
    rand_fields();
    s_axi_araddr  = 64'h0000_0000_8000_0000;
    s_axi_arid    = 2'd1;
    s_axi_arlen   = 8'd3;
    s_axi_arvalid = 1'b1;
    m_sc_recv     = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    chk_zero_outputs("rst");
    repeat (2) @(negedge aclk);
    #2 aresetn = 1'b1;

    drive_fixed_ar();
    repeat (2) drive(1'b0, 1'b0);

    // restore to full credit, then five back-to-back beats with no returns
    drive(1'b0, 1'b1);
    repeat (5) drive(1'b1, 1'b0);
    repeat (2) drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    repeat (2) drive(1'b0, 1'b0);

    // credits to 2, then send and return on the same edge
    repeat (2) drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    repeat (2) drive(1'b0, 1'b0);
    repeat (2) drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    repeat (3) drive(1'b0, 1'b0);

    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);

    // exhaust credits and fill the buffer, then reset mid-cycle
    repeat (10) drive(1'b1, 1'b0);
    @(negedge aclk);
    #3;
    aresetn       = 1'b0;
    s_axi_arvalid = 1'b0;
    m_sc_recv     = 1'b0;
    model_reset();
    #1;
    chk_zero_outputs("midrst");
    repeat (2) @(negedge aclk);
    #2 aresetn = 1'b1;

    repeat (5) drive(1'b0, 1'b0);
    repeat (5) drive(1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b0);
    for (int i = 0; i < 100; i++)
      drive($urandom_range(0, 1) != 0, $urandom_range(0, 3) == 0);
    repeat (4) drive(1'b0, 1'b1);
    repeat (3) drive(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
